// File: rtl/tx_preamble_pkg.sv
// ---------------------------------------------------------------------------
// tx_preamble_pkg
// Shared constants for the TX preamble inserter and the RX timing-acquisition
// correlator: sample format, preamble geometry, the STF and LTF base
// sequences, FSM state encodings and a helper that flattens STF + LTF guard +
// LTF repetitions into one sample table.
// No ports (package).
// ---------------------------------------------------------------------------
package tx_preamble_pkg;

    localparam int DATAWIDTH   = 16;
    localparam int PHASES      = 64;
    localparam int PERIODICITY = 16;
    localparam int STF_REPS    = 10;
    localparam int LTF_SIZE    = 64;
    localparam int LTF_CP      = 32;
    localparam int LTF_REPS    = 2;
    localparam int INT_BITS    = 0;
    localparam int FRAC_BITS   = 15;

    localparam int STF_LEN    = PERIODICITY * STF_REPS;
    localparam int PRE_LEN    = STF_LEN + LTF_CP + LTF_SIZE * LTF_REPS;
    localparam int PRE_BEATS  = PRE_LEN / PHASES;
    localparam int BEAT_W     = DATAWIDTH * PHASES;
    localparam int BEAT_CNT_W = (PRE_BEATS > 1) ? $clog2(PRE_BEATS) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREAMBLE = 2'd1;
    localparam logic [1:0] PAYLOAD  = 2'd2;

    typedef logic signed [DATAWIDTH-1:0] sample_t;
    typedef logic [PERIODICITY-1:0][DATAWIDTH-1:0] stf_seq_t;
    typedef logic [LTF_SIZE-1:0][DATAWIDTH-1:0]    ltf_seq_t;
    typedef logic [PRE_LEN-1:0][DATAWIDTH-1:0]     pre_table_t;

    // Constant-envelope sequences: every sample is +/-AMP, bit k of the
    // sign mask set means sample k is negative. Q0.15: 0x2D41 ~ 0.354,
    // 0x4000 = 0.5.
    localparam sample_t STF_AMP = 16'sh2D41;
    localparam sample_t LTF_AMP = 16'sh4000;

    localparam logic [PERIODICITY-1:0] STF_RE_NEG = 16'h4E3A;
    localparam logic [PERIODICITY-1:0] STF_IM_NEG = 16'hB1C5;
    localparam logic [LTF_SIZE-1:0]    LTF_RE_NEG = 64'hA5C3_1E7B_96F0_3C5D;
    localparam logic [LTF_SIZE-1:0]    LTF_IM_NEG = 64'h3B9E_C417_5AD2_E864;

    function automatic stf_seq_t build_stf(input logic [PERIODICITY-1:0] neg);
        stf_seq_t seq;
        for (int k = 0; k < PERIODICITY; k++) begin
            seq[k] = neg[k] ? -STF_AMP : STF_AMP;
        end
        return seq;
    endfunction

    function automatic ltf_seq_t build_ltf(input logic [LTF_SIZE-1:0] neg);
        ltf_seq_t seq;
        for (int k = 0; k < LTF_SIZE; k++) begin
            seq[k] = neg[k] ? -LTF_AMP : LTF_AMP;
        end
        return seq;
    endfunction

    // Element n of the table is preamble sample n, so a flat slice of
    // PHASES elements starting at beat*PHASES is already in output packing.
    function automatic pre_table_t build_preamble(input stf_seq_t stf, input ltf_seq_t ltf);
        pre_table_t tbl;
        for (int n = 0; n < PRE_LEN; n++) begin
            if (n < STF_LEN) begin
                tbl[n] = stf[n % PERIODICITY];
            end else if (n < STF_LEN + LTF_CP) begin
                tbl[n] = ltf[LTF_SIZE - LTF_CP + (n - STF_LEN)];
            end else begin
                tbl[n] = ltf[(n - STF_LEN - LTF_CP) % LTF_SIZE];
            end
        end
        return tbl;
    endfunction

    localparam stf_seq_t STF_SEQ_RE = build_stf(STF_RE_NEG);
    localparam stf_seq_t STF_SEQ_IM = build_stf(STF_IM_NEG);
    localparam ltf_seq_t LTF_SEQ_RE = build_ltf(LTF_RE_NEG);
    localparam ltf_seq_t LTF_SEQ_IM = build_ltf(LTF_IM_NEG);

    localparam pre_table_t PRE_TABLE_RE = build_preamble(STF_SEQ_RE, LTF_SEQ_RE);
    localparam pre_table_t PRE_TABLE_IM = build_preamble(STF_SEQ_IM, LTF_SEQ_IM);

endpackage

// File: rtl/preamble_rom.sv
// ---------------------------------------------------------------------------
// preamble_rom
// Combinational preamble lookup: beat index -> PHASES complex samples.
//   beat     in   BEAT_CNT_W  preamble beat index (0 .. PRE_BEATS-1)
//   beat_re  out  BEAT_W      I samples, sample 0 in the low DATAWIDTH bits
//   beat_im  out  BEAT_W      Q samples, same packing
// Indices past the last beat return zero.
// ---------------------------------------------------------------------------
module preamble_rom
    import tx_preamble_pkg::*;
(
    input  logic [BEAT_CNT_W-1:0] beat,
    output logic [BEAT_W-1:0]     beat_re,
    output logic [BEAT_W-1:0]     beat_im
);

    // Constant-index mux over the beats keeps every table select static.
    always_comb begin
        beat_re = '0;
        beat_im = '0;
        for (int b = 0; b < PRE_BEATS; b++) begin
            if (beat == BEAT_CNT_W'(b)) begin
                beat_re = PRE_TABLE_RE[b*PHASES +: PHASES];
                beat_im = PRE_TABLE_IM[b*PHASES +: PHASES];
            end
        end
    end

endmodule

// File: rtl/preamble_inserter.sv
// ---------------------------------------------------------------------------
// preamble_inserter
// On start_i emits the fixed STF+LTF preamble (PRE_BEATS beats of PHASES
// complex samples), then forwards payload beats unchanged until s_last_i.
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             frame request, only honoured in IDLE
//   s_re_i/s_im_i       payload I/Q beat, sample n at [(n+1)*DW-1 -: DW]
//   s_valid_i/s_last_i  payload beat valid / last beat of frame
//   s_ready_o           payload beat accepted when s_valid_i & s_ready_o
//   m_re_o/m_im_o       output I/Q beat, same packing
//   m_valid_o/m_ready_i output handshake
//   m_sof_o             marks the first preamble beat
//   m_last_o            marks the last payload beat
//   busy_o              high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module preamble_inserter
    import tx_preamble_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [BEAT_W-1:0] s_re_i,
    input  logic [BEAT_W-1:0] s_im_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic [BEAT_W-1:0] m_re_o,
    output logic [BEAT_W-1:0] m_im_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_sof_o,
    output logic              m_last_o,
    output logic              busy_o
);

    if ((PRE_LEN % PHASES) != 0) begin : g_len_check
        $fatal(1, "preamble_inserter: preamble length is not a whole number of beats");
    end

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(PRE_BEATS - 1);

    logic [1:0]            state;
    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0]     rom_re;
    logic [BEAT_W-1:0]     rom_im;
    logic                  load_en;
    logic                  accept;

    preamble_rom u_rom (
        .beat    (beat_cnt),
        .beat_re (rom_re),
        .beat_im (rom_im)
    );

    // Single output register with no skid buffer: it may load whenever it is
    // empty or being drained, so upstream ready follows m_ready_i directly.
    assign load_en   = !m_valid_o || m_ready_i;
    assign s_ready_o = (state == PAYLOAD) && load_en;
    assign accept    = s_valid_i && s_ready_o;
    assign busy_o    = (state != IDLE);

    // IDLE still drains the final payload beat, and a new start is taken
    // there even while that beat waits; the first preamble beat then loads
    // only once the register frees up.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            m_re_o    <= '0;
            m_im_o    <= '0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        m_valid_o <= 1'b0;
                        m_sof_o   <= 1'b0;
                        m_last_o  <= 1'b0;
                    end
                    if (start_i) begin
                        state    <= PREAMBLE;
                        beat_cnt <= '0;
                    end
                end
                PREAMBLE: begin
                    if (load_en) begin
                        m_re_o    <= rom_re;
                        m_im_o    <= rom_im;
                        m_valid_o <= 1'b1;
                        m_sof_o   <= (beat_cnt == '0);
                        m_last_o  <= 1'b0;
                        beat_cnt  <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        m_re_o    <= s_re_i;
                        m_im_o    <= s_im_i;
                        m_valid_o <= 1'b1;
                        m_sof_o   <= 1'b0;
                        m_last_o  <= s_last_i;
                        if (s_last_i) begin
                            state <= IDLE;
                        end
                    end else if (load_en) begin
                        m_valid_o <= 1'b0;
                        m_sof_o   <= 1'b0;
                        m_last_o  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
